// File: rtl/score_text_buf_if.sv
// score_text_buf_if: bundles the score-update and character-lookup signals
// of score_text_buf.
//   score, score_valid : binary score and its one-cycle capture strobe
//   vblnk_in           : vertical blank, only used by the frame-sync build
//   char_xy, char_code : renderer character index and registered ASCII code
//   busy               : high while a conversion or commit is in flight
// master drives score/strobe/vblank/index; slave is the buffer itself.
interface score_text_buf_if #(
  parameter int unsigned SCORE_WIDTH = 16
);
  logic [SCORE_WIDTH-1:0] score;
  logic                   score_valid;
  logic                   vblnk_in;
  logic [7:0]             char_xy;
  logic [7:0]             char_code;
  logic                   busy;

  modport master (
    output score, score_valid, vblnk_in, char_xy,
    input  char_code, busy
  );

  modport slave (
    input  score, score_valid, vblnk_in, char_xy,
    output char_code, busy
  );
endinterface

// File: rtl/score_text_buf.sv
// score_text_buf: character source for the text renderer. Holds the line
// "SCORE nnnnn" and converts a binary score to five decimal digits with a
// sequential double-dabble engine (16 shift cycles).
// Ports:
//   clk  : pixel clock shared with the renderer
//   rst  : asynchronous active-low reset
//   bus  : score_text_buf_if.slave (score/score_valid in, vblnk_in in,
//          char_xy in, char_code out registered one cycle, busy out)
// Optional build macro SCORE_FRAME_SYNC_EN: hold the new digits until the
// next rising edge of vblnk_in so the text never changes mid-frame.
module score_text_buf #(
  parameter int unsigned SCORE_WIDTH = 16,
  parameter int unsigned DIGITS      = 5,
  parameter int unsigned DIGIT_POS   = 6,
  parameter int unsigned LINE_CHARS  = 16,
  parameter logic [7:0]  BLANK_CODE  = 8'h20
) (
  input logic              clk,
  input logic              rst,
  score_text_buf_if.slave  bus
);

  localparam int unsigned BinW = 16;
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ShW  = BcdW + BinW;

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StWaitSync} state_e;

  state_e                       state_q, state_d;
  logic [ShW-1:0]               sh_q, sh_d, sh_adj;
  logic [3:0]                   iter_q, iter_d;
  logic [DIGITS-1:0][3:0]       work_q, work_d;
  logic [DIGITS-1:0][3:0]       disp_q, disp_d;
  logic [SCORE_WIDTH-1:0]       pend_q, pend_d;
  logic                         pend_vld_q, pend_vld_d;
  logic [7:0]                   char_code_q, char_code_d;
  logic                         sync_ok;

`ifdef SCORE_FRAME_SYNC_EN
  logic vblnk_q, vblnk_qq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q  <= 1'b0;
      vblnk_qq <= 1'b0;
    end else begin
      vblnk_q  <= bus.vblnk_in;
      vblnk_qq <= vblnk_q;
    end
  end

  assign sync_ok = vblnk_q & ~vblnk_qq;
`else
  assign sync_ok = 1'b1;
`endif

  // Double-dabble adjust step: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sh_q[BinW+4*i +: 4] >= 4'd5) begin
        sh_adj[BinW+4*i +: 4] = sh_q[BinW+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    iter_d     = iter_q;
    work_d     = work_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    // Strobes arriving while busy park in the one-deep pending slot; last wins.
    if (bus.score_valid && (state_q != StIdle)) begin
      pend_d     = bus.score;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.score_valid) begin
          sh_d    = {BcdW'(0), BinW'(bus.score)};
          iter_d  = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        sh_d   = {sh_adj[ShW-2:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = StCommit;
      end
      StCommit: begin
        work_d  = sh_q[ShW-1 -: BcdW];
        state_d = StWaitSync;
      end
      StWaitSync: begin
        if (sync_ok) begin
          disp_d = work_q;
          // A strobe in this very cycle is newer than anything pending.
          if (bus.score_valid) begin
            sh_d       = {BcdW'(0), BinW'(bus.score)};
            iter_d     = 4'd0;
            pend_vld_d = 1'b0;
            state_d    = StShift;
          end else if (pend_vld_q) begin
            sh_d       = {BcdW'(0), BinW'(pend_q)};
            iter_d     = 4'd0;
            pend_vld_d = 1'b0;
            state_d    = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Character lookup; registered below for a fixed one-cycle read latency.
  always_comb begin
    char_code_d = BLANK_CODE;
    if (32'(bus.char_xy) < LINE_CHARS) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (32'(bus.char_xy) == DIGIT_POS + k) char_code_d = {4'h3, disp_q[DIGITS-1-k]};
      end
      case (bus.char_xy)
        8'd0:    char_code_d = 8'h53;
        8'd1:    char_code_d = 8'h43;
        8'd2:    char_code_d = 8'h4F;
        8'd3:    char_code_d = 8'h52;
        8'd4:    char_code_d = 8'h45;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      iter_q      <= 4'd0;
      work_q      <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      char_code_q <= BLANK_CODE;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      iter_q      <= iter_d;
      work_q      <= work_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      char_code_q <= char_code_d;
    end
  end

  assign bus.char_code = char_code_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/score_text_buf.md
Name: score_text_buf

Overview:
- Character-source stage directly upstream of the rectangle text renderer.
- Converts a binary game score into ASCII decimal digits with a sequential double-dabble engine.
- Holds the resulting text line "SCORE nnnnn".
- On each character index requested by the renderer (char_xy), returns the ASCII code the renderer uses as the font ROM character address.

Parameters:
- SCORE_WIDTH, 16, width of the binary score input; legal range 1..16.
- DIGITS, 5, number of decimal digits displayed; fixed at 5 for SCORE_WIDTH ≤ 16.
- DIGIT_POS, 6, char index of the most-significant digit.
- LINE_CHARS, 16, characters per text row; indices ≥ LINE_CHARS return blank.
- BLANK_CODE, 8'h20, ASCII code returned for unused or out-of-range positions.

Ports:
- clk  in  1  pixel clock, shared with the renderer.
- rst  in  1  asynchronous, active-low reset.
- score  in  SCORE_WIDTH  binary score value.
- score_valid  in  1  single-cycle strobe: capture score.
- vblnk_in  in  1  vertical blank from the timing chain; used only for the frame-sync commit.
- char_xy  in  8  character index from the renderer (col + LINE_CHARS*row).
- char_code  out  8  ASCII code for char_xy, registered; feeds the renderer's addr_x_w.
- busy  out  1  high while a conversion is running.

Behaviour:
- Reset (rst=0, asynchronous):
  - char_code=BLANK_CODE, busy=0, FSM=IDLE.
  - Displayed and working digit registers all = 4'd0, shown as '0'.
  - Pending flag cleared.
- Static text:
  - index 0..4 = "SCORE" (8'h53,8'h43,8'h4F,8'h52,8'h45).
  - index 5 = BLANK_CODE.
  - index DIGIT_POS..DIGIT_POS+4 = digits, MSD first, code = 8'h30 + digit.
  - all other indices = BLANK_CODE.
  - All codes < 8'h80, because the renderer's font address keeps only 7 code bits.
- Read path: char_code <= lookup(char_xy) every cycle. Latency exactly 1 clk, no stall.
- Conversion FSM:
  - IDLE: on score_valid, load shift reg = {20'd0, score zero-extended to 16}, iter=0, busy=1 -> SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left 1; iter+1. After 16 shifts -> COMMIT. busy stays 1.
  - COMMIT: copy the five BCD nibbles to the working digit registers -> WAIT_SYNC.
  - WAIT_SYNC: copy working to displayed digits immediately (see Optional Feature). busy=0 -> IDLE, or -> SHIFT if a value is pending.
  - Conversion latency: 18 clk from strobe to displayed update (1 load + 16 shift + 1 commit), no frame sync.
- Back-pressure / simultaneous events:
  - score_valid while busy: the value is stored in a one-deep pending register and the pending flag is set.
  - A later strobe while busy overwrites the pending value (last value wins).
  - Pending is consumed on the WAIT_SYNC exit.
- Displayed digits only ever change as a whole; no partially converted value is ever readable.
- Reset mid-conversion aborts it; the display returns to "00000".

Optional Feature:
- Macro SCORE_FRAME_SYNC_EN.
- Defined:
  - WAIT_SYNC holds until a rising edge of vblnk_in (registered one cycle), then commits working to displayed.
  - The text therefore never changes mid-frame.
  - busy stays 1 until the commit.
- Undefined: WAIT_SYNC commits in the same cycle it is entered; vblnk_in is unused.

Test Plan:
- Reset release, sweep char_xy 0..15 -> codes 53,43,4F,52,45,20,30,30,30,30,30,20,20,20,20,20 (hex), each one clk after its char_xy.
- score=16'd1234 strobe -> busy high 18 clk; then index 6..10 = 30,31,32,33,34.
- score=16'd65535 -> digits 36,35,35,33,35. score=0 -> all 30.
- Strobes 100 then 200 then 300 while busy -> displays 100, then 300; 200 never appears.
- char_xy=16 and char_xy=255 -> char_code 8'h20.
- SCORE_FRAME_SYNC_EN defined: strobe 42 with vblnk_in low -> digits unchanged until vblnk_in rises, then "00042" within 2 clk. Assert rst mid-SHIFT -> "00000", busy=0 immediately.
